mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Parametrised N-channel arbiter that shares one synchronous single-port block RAM between requesters
//   (UART IO loader, processor cache, future DMA).
//   Supersedes fixed switch-gated dual-port wiring: per-channel enables, round-robin or fixed priority,
//   configurable RAM read latency, one outstanding transaction.
//   Sits between requesters and the bram instance on the clk_100-derived system clock.
// PARAMETERS
//   NCH       2   number of requester channels (1..8)
//   DATA_W    16  data width
//   ADDR_W    16  address width (passed unchanged to memory)
//   RD_LAT    1   BRAM read latency in cycles, from the mem_en cycle to mem_rdata valid (1..4)
//   PRIO_MODE 0   0 = round-robin, 1 = fixed priority (lowest index wins)
// PORTS
//   clk_100    in   1            system clock, all logic on rising edge
//   rst_n      in   1            synchronous, active-low reset
//   ch_en      in   NCH          per-channel enable; a disabled channel is never granted
//   req_valid  in   NCH          request pending; held until req_ready
//   req_we     in   NCH          1 = write, 0 = read
//   req_addr   in   NCH*ADDR_W   packed addresses, ch i at [i*ADDR_W +: ADDR_W]
//   req_wdata  in   NCH*DATA_W   packed write data
//   req_ready  out  NCH          one-cycle accept pulse to the granted channel
//   rsp_valid  out  NCH          one-cycle read-data-valid pulse
//   rsp_rdata  out  DATA_W       read data, shared bus, valid with rsp_valid
//   mem_en     out  1            BRAM enable
//   mem_we     out  1            BRAM write enable
//   mem_addr   out  ADDR_W       BRAM address
//   mem_wdata  out  DATA_W       BRAM write data
//   mem_rdata  in   DATA_W       BRAM read data
//   busy       out  1            high in every state except IDLE
//   grant_id   out  clog2(NCH)   index of the current or last granted channel (min width 1)
// BEHAVIOUR
//   All outputs are registered.
//   Reset (rst_n=0 at an edge):
//     - state=IDLE; every output 0; rr pointer=NCH-1, so ch0 wins first.
//     - Reset mid-transaction aborts it: no req_ready or rsp_valid is issued afterwards.
//   FSM IDLE -> ISSUE -> (write: IDLE | read: WAIT -> RESP -> IDLE).
//   IDLE:
//     - eligible = req_valid & ch_en.
//     - If eligible != 0: pick a winner, latch its we/addr/wdata, go to ISSUE.
//     - Otherwise stay in IDLE.
//   Arbitration:
//     - PRIO_MODE=0: first eligible index searching from rr+1 upward, wrapping at NCH-1 -> 0;
//       rr updates to the winner at grant.
//     - PRIO_MODE=1: lowest eligible index wins; rr unused.
//   ISSUE (1 cycle):
//     - mem_en=1, mem_we=latched we, mem_addr/mem_wdata from the latched request.
//     - req_ready[winner]=1; grant_id=winner.
//     - Write: next state IDLE. Read: next state WAIT, latency counter loaded with RD_LAT-1.
//   WAIT:
//     - mem_en=0; counter decrements.
//     - At 0, or immediately when RD_LAT=1, go to RESP and capture mem_rdata at that edge.
//   RESP (1 cycle):
//     - rsp_valid[winner]=1, rsp_rdata=captured data; next state IDLE.
//   Latency:
//     - Write: request seen in IDLE at cycle 0 -> mem_en and req_ready at cycle 1; IDLE again at cycle 2.
//     - Read: rsp_valid at cycle 2+RD_LAT.
//     - Back-to-back throughput: one write per 2 cycles, one read per 3+RD_LAT cycles.
//   Boundaries:
//     - ch_en drop mid-transaction: the transaction completes and rsp is delivered; the channel is
//       ineligible from the next IDLE.
//     - req_valid drop before req_ready: the latched request still executes; the requester must not
//       drop early.
//     - All channels requesting at once: exactly one req_ready per ISSUE; round-robin never starves
//       an enabled channel (wait <= NCH grants).
//     - Address wrap-around is not handled here: addr is passed verbatim.
//     - rsp_rdata holds its last value outside RESP.
//     - mem_we=0 whenever mem_en=0.
// TESTING
//   1. Reset: rst_n=0 for 3 cycles with all req_valid=1 -> every output 0, busy=0.
//      Release -> ch0 granted first.
//   2. Single write: ch1 we=1, addr=0x0010, wdata=0xBEEF.
//      -> cycle 1: mem_en=1, mem_we=1, mem_addr=0x0010, req_ready=2'b10. Cycle 2: busy=0.
//   3. Read-back, RD_LAT=2: ch1 read 0x0010 with model RAM.
//      -> rsp_valid[1]=1 at cycle 4, rsp_rdata=0xBEEF; no other rsp_valid.
//   4. Round-robin: NCH=4, all ch_en=1, all req_valid held.
//      -> grant order 0,1,2,3,0; with PRIO_MODE=1 -> 0,0,0...
//   5. Enable gating: ch_en=4'b1101, ch1 requesting -> ch1 never granted.
//      ch_en[2] dropped during WAIT of a ch2 read -> rsp_valid[2] still pulses.
//   6. Mid-op reset: rst_n=0 in the WAIT state -> no rsp_valid.
//      Next grant after release goes to ch0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter sharing one synchronous single-port BRAM; one outstanding transaction,
// round-robin or fixed priority, configurable read latency. All outputs are registered.
module mem_port_arbiter #(
  parameter int NCH       = 2,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0,
  localparam int GW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk_100,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        ch_en,
  input  logic [NCH-1:0]        req_valid,
  input  logic [NCH-1:0]        req_we,
  input  logic [NCH*ADDR_W-1:0] req_addr,
  input  logic [NCH*DATA_W-1:0] req_wdata,
  output logic [NCH-1:0]        req_ready,
  output logic [NCH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic [GW-1:0]         grant_id
);

  // Handshake: a requester holds req_valid until it sees its one-cycle req_ready pulse;
  // read data arrives later as a one-cycle rsp_valid pulse on the same channel index.

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q;
  logic [GW-1:0]       rr_q;
  logic [GW-1:0]       grant_id_q;
  logic                we_q;
  logic [CW-1:0]       cnt_q;
  logic [NCH-1:0]      req_ready_q;
  logic [NCH-1:0]      rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                busy_q;

  logic [NCH-1:0]      eligible;
  logic [GW-1:0]       win_d;
  logic                found;
  int                  idx;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Round-robin scans from rr+1 with wrap; fixed priority scans from index 0.
  always_comb begin
    eligible = req_valid & ch_en;
    win_d    = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NCH; k++) begin
      if (PRIO_MODE != 0) idx = k - 1;
      else                idx = (int'(rr_q) + k) % NCH;
      if (!found && eligible[idx]) begin
        win_d = GW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (win_d == GW'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= GW'(NCH - 1);
      grant_id_q  <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            state_q            <= S_ISSUE;
            busy_q             <= 1'b1;
            rr_q               <= win_d;
            grant_id_q         <= win_d;
            we_q               <= sel_we;
            mem_en_q           <= 1'b1;
            mem_we_q           <= sel_we;
            mem_addr_q         <= sel_addr;
            mem_wdata_q        <= sel_wdata;
            req_ready_q[win_d] <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (we_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= CW'(RD_LAT - 1);
          end
        end
        S_WAIT: begin
          // mem_rdata is valid in the last WAIT cycle; capture it on the way into RESP.
          if (cnt_q == '0) begin
            state_q                 <= S_RESP;
            rsp_valid_q[grant_id_q] <= 1'b1;
            rsp_rdata_q             <= mem_rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule
